ebnb_buffer: RTL and testbench
==============================

Name: ebnb_buffer

Overview:
- Parametrised N-deep elastic buffer with full valid/ready handshake on both sides; successor to the 2-entry elastic buffer datapath.
- Integrates the datapath and its control (no external en/sel), so stages can be registered and decoupled without hand-built control logic.
- Sits between any two streaming stages in the FPGA pipelines.
- Breaks both the forward path (data/valid) and the backward path (ready) with flops.
- Adds occupancy reporting and a synchronous flush.

Parameters:
- WIDTH, 8, data width in bits of t_0_data and i_0_data.
- DEPTH, 4, capacity in words; must be a power of two and ≥ 2.
- CNT_W, $clog2(DEPTH+1), width of the count output; derived, not overridden.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all contents.
- t_0_data  input  WIDTH  upstream data.
- t_0_valid  input  1  upstream word valid.
- t_0_ready  output  1  buffer can accept a word this cycle.
- i_0_data  output  WIDTH  downstream data (head of buffer).
- i_0_valid  output  1  head word valid.
- i_0_ready  input  1  downstream accepts head.
- count  output  CNT_W  words currently held, 0..DEPTH.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately without a clock edge):
  - i_0_valid=0, t_0_ready=1, count=0, i_0_data=0.
  - Read/write pointers are cleared to 0.
- Push = t_0_valid & t_0_ready. Pop = i_0_valid & i_0_ready. Both are evaluated at the rising edge.
- t_0_ready, i_0_valid, i_0_data and count are driven directly from flops. There is no combinational path input→output.
  - t_0_ready does not depend on i_0_ready in the same cycle.
- Latency: a word pushed into an empty buffer at edge N appears with i_0_valid=1 in the cycle after N.
- Throughput: one word per cycle sustained when both sides are continuously valid/ready, for any DEPTH ≥ 2. No bubbles.
- t_0_ready = (count_next < DEPTH), registered.
  - When full, a pop does not enable a push in the same cycle; ready rises the cycle after the pop.
  - When pushing into a slot that leaves the buffer full, ready falls the cycle after that push.
- Data ordering: strict FIFO.
  - While i_0_valid=1 and i_0_ready=0, i_0_data and i_0_valid are held stable.
  - Once valid is asserted, it is never withdrawn except by flush or reset.
- count_next rules:
  - push&!pop → +1.
  - pop&!push → −1.
  - both or neither → unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. Full and empty are distinguished by count, not by pointer equality.
- Simultaneous push and pop with count=1: the head advances to the new word; i_0_valid stays 1; count stays 1.
- flush (synchronous):
  - Has priority over push and pop in the same cycle. The upstream word is dropped, and downstream acceptance that cycle is treated as not occurring.
  - The next cycle is identical to the post-reset state, except that i_0_data keeps its last value.
- Storage is a flop array, with no reset on the array contents. The head register is reset.
- t_0_valid is ignored when t_0_ready=0. Sources may hold or change data freely.

Decomposition:
- Package ebnb_pkg holds:
  - the ptr_t/cnt_t typedef helpers, as parametrised-width macros;
  - the elaboration checks (DEPTH power of two, ≥ 2), as a function used in an initial assertion.
- One sub-module, ebnb_ctrl, owns the pointers, count, t_0_ready and i_0_valid, and issues write-enable, read-advance and head-load strobes.
- The top level instantiates ebnb_ctrl plus the storage array and the head register.

Test Plan (WIDTH=8, DEPTH=4):
- Reset, then push 0xA5 with i_0_ready=0 → the cycle after the push: i_0_valid=1, i_0_data=0xA5, count=1. Data holds 0xA5 for 5 stalled cycles.
- Push 0x01..0x04 with i_0_ready=0 → count=4. t_0_ready=0 the cycle after the 4th push. A 5th word 0x05 held valid for 3 cycles is not accepted; count remains 4.
- From full, pop one cycle → the next cycle t_0_ready=1 and count=3. In the pop cycle itself, t_0_ready stays 0. Drained output order is 0x01,0x02,0x03,0x04.
- Stream 0x00..0x0F with t_0_valid=i_0_ready=1 continuously → outputs 0x00..0x0F on 16 consecutive cycles starting 1 cycle after the first push. count stays 1; no bubbles; pointers wrap four times.
- Hold 3 words, assert flush for one cycle while pushing 0x77 and i_0_ready=1 → the next cycle: i_0_valid=0, count=0, t_0_ready=1. 0x77 never appears at the output.
- Mid-stream, drop reset_n between clock edges → i_0_valid=0, t_0_ready=1, count=0 immediately. After release, a push of 0x3C emerges one cycle later.

Source files
------------

// File: rtl/ebnb_pkg.sv
// Shared helpers for the N-deep elastic buffer: pointer/count type macros and
// the elaboration-time depth check.
`ifndef EBNB_PKG_MACROS
`define EBNB_PKG_MACROS
`define EBNB_PTR_T(D) logic [$clog2(D)-1:0]
`define EBNB_CNT_T(D) logic [$clog2((D)+1)-1:0]
`endif

package ebnb_pkg;

    // Pointers wrap naturally only when the depth is a power of two.
    function automatic bit depth_ok(input int unsigned d);
        return (d >= 32'd2) && ((d & (d - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/ebnb_ctrl.sv
// Elastic buffer control: pointers, occupancy, registered ready/valid and the
// storage/head strobes.
module ebnb_ctrl
    import ebnb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             t_valid,
    input  logic             i_ready,
    output logic             t_ready,
    output logic             i_valid,
    output logic [CNT_W-1:0] count,
    output logic             wr_en_c,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_addr_c,
    output logic             head_load_c,
    output logic             head_bypass_c
);

    typedef `EBNB_PTR_T(DEPTH) ptr_t;
    typedef `EBNB_CNT_T(DEPTH) cnt_t;

    ptr_t rd_ptr;
    ptr_t rd_ptr_nx;
    ptr_t wr_ptr_nx;
    cnt_t count_nx;
    logic push;
    logic pop;

    // Flush overrides both handshakes; the head is refilled whenever the slot
    // it shows is consumed or the buffer was empty.
    always_comb begin
        push          = t_valid & t_ready & ~flush;
        pop           = i_valid & i_ready & ~flush;
        count_nx      = count;
        rd_ptr_nx     = rd_ptr + PTR_W'(pop);
        wr_ptr_nx     = wr_ptr + PTR_W'(push);
        if (flush) begin
            count_nx  = '0;
            rd_ptr_nx = '0;
            wr_ptr_nx = '0;
        end else if (push && !pop) begin
            count_nx  = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nx  = count - CNT_W'(1);
        end
        wr_en_c       = push;
        rd_addr_c     = rd_ptr_nx;
        head_load_c   = ~flush & (count_nx != '0) & (pop | (count == '0));
        head_bypass_c = push & ((count - CNT_W'(pop)) == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            t_ready <= 1'b1;
            i_valid <= 1'b0;
        end else begin
            rd_ptr  <= rd_ptr_nx;
            wr_ptr  <= wr_ptr_nx;
            count   <= count_nx;
            t_ready <= count_nx < CNT_W'(DEPTH);
            i_valid <= count_nx != '0;
        end
    end

endmodule

// File: rtl/ebnb_buffer.sv
// N-deep elastic buffer with registered valid/ready on both sides, occupancy
// count and synchronous flush.
module ebnb_buffer
    import ebnb_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] t_0_data,
    input  logic             t_0_valid,
    output logic             t_0_ready,
    output logic [WIDTH-1:0] i_0_data,
    output logic             i_0_valid,
    input  logic             i_0_ready,
    output logic [CNT_W-1:0] count
);

    typedef `EBNB_PTR_T(DEPTH) ptr_t;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("ebnb_buffer: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_addr_c;
    logic             wr_en_c;
    logic             head_load_c;
    logic             head_bypass_c;

    ebnb_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .t_valid       (t_0_valid),
        .i_ready       (i_0_ready),
        .t_ready       (t_0_ready),
        .i_valid       (i_0_valid),
        .count         (count),
        .wr_en_c       (wr_en_c),
        .wr_ptr        (wr_ptr),
        .rd_addr_c     (rd_addr_c),
        .head_load_c   (head_load_c),
        .head_bypass_c (head_bypass_c)
    );

    // Storage array carries no reset; only words below count are ever shown.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= t_0_data;
        end
    end

    // Head register: bypass the incoming word when it becomes the new head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_0_data <= '0;
        end else if (head_load_c) begin
            i_0_data <= head_bypass_c ? t_0_data : mem[rd_addr_c];
        end
    end

endmodule

// File: tb/tb_ebnb_buffer.sv
// Directed vector bench for ebnb_buffer (WIDTH=8, DEPTH=4).
module tb_ebnb_buffer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic [7:0] t_0_data;
    logic       t_0_valid;
    logic       t_0_ready;
    logic [7:0] i_0_data;
    logic       i_0_valid;
    logic       i_0_ready;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    ebnb_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .t_0_data  (t_0_data),
        .t_0_valid (t_0_valid),
        .t_0_ready (t_0_ready),
        .i_0_data  (i_0_data),
        .i_0_valid (i_0_valid),
        .i_0_ready (i_0_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tv;
        logic [7:0] td;
        logic       ir;
        logic       fl;
        logic       ev;
        logic       er;
        logic [2:0] ec;
        logic       cd;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic tv, logic [7:0] td, logic ir, logic fl,
                                logic ev, logic er, logic [2:0] ec,
                                logic cd, logic [7:0] ed);
        vec_t v;
        v.tv = tv; v.td = td; v.ir = ir; v.fl = fl;
        v.ev = ev; v.er = er; v.ec = ec; v.cd = cd; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic state(input string tag, input logic ev, input logic er,
                         input logic [2:0] ec, input logic cd, input logic [7:0] ed);
        chk({tag, ".valid"}, 32'(i_0_valid), 32'(ev));
        chk({tag, ".ready"}, 32'(t_0_ready), 32'(er));
        chk({tag, ".count"}, 32'(count), 32'(ec));
        if (cd) chk({tag, ".data"}, 32'(i_0_data), 32'(ed));
    endtask

    // Drive inputs just after an edge, advance one edge, sample 1 time unit later.
    task automatic tick(input logic tv, input logic [7:0] td, input logic ir, input logic fl);
        t_0_valid = tv; t_0_data = td; i_0_ready = ir; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; t_0_valid = 1'b0; t_0_data = 8'h00; i_0_ready = 1'b0;
        #12;
        state("reset", 1'b0, 1'b1, 3'd0, 1'b1, 8'h00);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single word with stalled sink
        vecs.push_back(mk(1, 8'hA5, 0, 0, 1, 1, 3'd1, 1, 8'hA5));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 3'd1, 1, 8'hA5));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 3'd0, 0, 8'h00));
        // fill to full, then present a word that must be refused
        vecs.push_back(mk(1, 8'h01, 0, 0, 1, 1, 3'd1, 1, 8'h01));
        vecs.push_back(mk(1, 8'h02, 0, 0, 1, 1, 3'd2, 1, 8'h01));
        vecs.push_back(mk(1, 8'h03, 0, 0, 1, 1, 3'd3, 1, 8'h01));
        vecs.push_back(mk(1, 8'h04, 0, 0, 1, 0, 3'd4, 1, 8'h01));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 8'h05, 0, 0, 1, 0, 3'd4, 1, 8'h01));
        // pop from full while 0x05 is still offered: ready was low, no push
        vecs.push_back(mk(1, 8'h05, 1, 0, 1, 1, 3'd3, 1, 8'h02));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 3'd2, 1, 8'h03));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 3'd1, 1, 8'h04));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 3'd0, 0, 8'h00));
        // flush with 3 held words, concurrent push of 0x77 and pop
        vecs.push_back(mk(1, 8'h10, 0, 0, 1, 1, 3'd1, 1, 8'h10));
        vecs.push_back(mk(1, 8'h11, 0, 0, 1, 1, 3'd2, 1, 8'h10));
        vecs.push_back(mk(1, 8'h12, 0, 0, 1, 1, 3'd3, 1, 8'h10));
        vecs.push_back(mk(1, 8'h77, 1, 1, 0, 1, 3'd0, 1, 8'h10));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 3'd0, 1, 8'h10));
        vecs.push_back(mk(1, 8'h55, 0, 0, 1, 1, 3'd1, 1, 8'h55));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 3'd0, 0, 8'h00));

        foreach (vecs[i]) begin
            tick(vecs[i].tv, vecs[i].td, vecs[i].ir, vecs[i].fl);
            state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ec,
                  vecs[i].cd, vecs[i].ed);
        end

        // continuous stream: one word per cycle, pointers wrap four times
        for (int k = 0; k < 16; k++) begin
            tick(1'b1, 8'(k), 1'b1, 1'b0);
            state($sformatf("stream%0d", k), 1'b1, 1'b1, 3'd1, 1'b1, 8'(k));
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        state("stream_end", 1'b0, 1'b1, 3'd0, 1'b0, 8'h00);

        // asynchronous reset between edges
        tick(1'b1, 8'h21, 1'b0, 1'b0);
        tick(1'b1, 8'h22, 1'b0, 1'b0);
        state("pre_rst", 1'b1, 1'b1, 3'd2, 1'b1, 8'h21);
        t_0_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        state("async_rst", 1'b0, 1'b1, 3'd0, 1'b1, 8'h00);
        #1;
        reset_n = 1'b1;
        tick(1'b1, 8'h3C, 1'b0, 1'b0);
        state("post_rst", 1'b1, 1'b1, 3'd1, 1'b1, 8'h3C);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        state("post_rst_pop", 1'b0, 1'b1, 3'd0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
